alu_op_sequencer: RTL

//  Control-side initiator for the datapath ALU: takes a 5-bit opcode plus start, walks a fixed

---
 rtl/alu_op_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// ALU register-transfer sequencer: Y load, execute, Z/LO/HI write-back with one-hot ALU strobes.
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes park in a sticky TRAP state until clear.
module alu_op_sequencer #(
  parameter int unsigned MULDIV_EXEC_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [13:0] alu_op,
  output logic        ra_out,
  output logic        rb_out,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        rz_in,
  output logic        lo_in,
  output logic        hi_in
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Strobe bit positions, MSB first: {ADD,SUB,MUL,DIV,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT,IncPC}
  localparam int B_ADD  = 13;
  localparam int B_SUB  = 12;
  localparam int B_MUL  = 11;
  localparam int B_DIV  = 10;
  localparam int B_AND  = 9;
  localparam int B_OR   = 8;
  localparam int B_SHR  = 7;
  localparam int B_SHRA = 6;
  localparam int B_SHL  = 5;
  localparam int B_ROR  = 4;
  localparam int B_ROL  = 3;
  localparam int B_NEG  = 2;
  localparam int B_NOT  = 1;

  // Out-of-range settings are clamped to the 1..15 range the 4-bit counter can hold.
  localparam int unsigned MD_CYC = (MULDIV_EXEC_CYCLES < 1)  ? 1 :
                                   (MULDIV_EXEC_CYCLES > 15) ? 15 : MULDIV_EXEC_CYCLES;
  localparam logic [3:0] EXEC_RELOAD = 4'(MD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WB_LO,
    S_WB_HI,
    S_DONE,
    S_TRAP
  } state_t;

  state_t     state;
  logic [4:0] op_q;
  logic [3:0] exec_cnt;

  function automatic logic is_binary(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
      OP_ROL, OP_AND, OP_OR, OP_MUL, OP_DIV: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [13:0] strobe_of(input logic [4:0] op);
    logic [13:0] s;
    s = '0;
    case (op)
      OP_ADD:  s[B_ADD]  = 1'b1;
      OP_SUB:  s[B_SUB]  = 1'b1;
      OP_MUL:  s[B_MUL]  = 1'b1;
      OP_DIV:  s[B_DIV]  = 1'b1;
      OP_AND:  s[B_AND]  = 1'b1;
      OP_OR:   s[B_OR]   = 1'b1;
      OP_SHR:  s[B_SHR]  = 1'b1;
      OP_SHRA: s[B_SHRA] = 1'b1;
      OP_SHL:  s[B_SHL]  = 1'b1;
      OP_ROR:  s[B_ROR]  = 1'b1;
      OP_ROL:  s[B_ROL]  = 1'b1;
      OP_NEG:  s[B_NEG]  = 1'b1;
      OP_NOT:  s[B_NOT]  = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      op_q     <= '0;
      exec_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= opcode;
            if (is_binary(opcode)) begin
              state <= S_LOAD_Y;
            end else if (is_unary(opcode)) begin
              state    <= S_EXEC;
              exec_cnt <= '0;
            end else begin
`ifdef ILLEGAL_TRAP_EN
              state <= S_TRAP;
`else
              state <= S_DONE;
`endif
            end
          end
        end
        S_LOAD_Y: begin
          state    <= S_EXEC;
          exec_cnt <= is_muldiv(op_q) ? EXEC_RELOAD : 4'd0;
        end
        // EXEC holds until the down-counter reaches zero; single-cycle ops enter with zero.
        S_EXEC: begin
          if (exec_cnt == 4'd0) begin
            state <= S_WB_LO;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
          end
        end
        S_WB_LO: state <= is_muldiv(op_q) ? S_WB_HI : S_DONE;
        S_WB_HI: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:  state <= S_TRAP;
`else
        S_TRAP:  state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: every output depends only on the registered state and op_q.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    alu_op    = '0;
    ra_out    = 1'b0;
    rb_out    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    rz_in     = 1'b0;
    lo_in     = 1'b0;
    hi_in     = 1'b0;
    case (state)
      S_IDLE: ;
      S_LOAD_Y: begin
        busy   = 1'b1;
        ra_out = 1'b1;
        y_in   = 1'b1;
      end
      S_EXEC: begin
        busy   = 1'b1;
        rb_out = 1'b1;
        z_in   = 1'b1;
        alu_op = strobe_of(op_q);
      end
      S_WB_LO: begin
        busy     = 1'b1;
        zlow_out = 1'b1;
        lo_in    = is_muldiv(op_q);
        rz_in    = ~is_muldiv(op_q);
      end
      S_WB_HI: begin
        busy      = 1'b1;
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
`ifndef ILLEGAL_TRAP_EN
        // An illegal opcode reaches DONE straight from IDLE; flag it for this one cycle.
        illegal = ~(is_binary(op_q) | is_unary(op_q));
`endif
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        busy    = 1'b1;
        illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule
